// File: rtl/psx_defs.sv
// Shared constants and state encoding for the PSX source loader.
package psx_defs;

    localparam int ADDR_W  = 5;
    localparam int MAX_LEN = 32;

    // Header byte: flag in bit 7, reserved bits 6:5 must be zero, start address in 4:0
    localparam logic [7:0] HDR_MASK = 8'hE0;
    localparam logic [7:0] HDR_FLAG = 8'h80;
    localparam logic [7:0] HDR_RSVD = 8'h60;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LENGTH,
        S_DATA,
        S_CHECK,
        S_COMMIT
    } state_t;

    function automatic logic is_header(input logic [7:0] b);
        return (b & HDR_MASK) == HDR_FLAG;
    endfunction

endpackage

// File: rtl/psx_loader_buffer.sv
// 32x8 packet buffer: one synchronous write port, one asynchronous read port.
module psx_loader_buffer
    import psx_defs::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/psx_source_loader.sv
// Host byte-stream packet loader feeding the quad controller data source.
// Define PSX_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module psx_source_loader
    import psx_defs::*;
#(
    parameter int CLOCK_MHZ = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] write_addr,
    output logic [7:0]        write_data,
    output logic              write_en,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int TMO_LIMIT = CLOCK_MHZ * 1000;
    localparam int TMO_W     = $clog2(TMO_LIMIT + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state, state_n;
    logic [ADDR_W-1:0] start_q, start_n;
    logic [5:0]        len_q, len_n;
    logic [5:0]        idx_q, idx_n;
    logic [7:0]        sum_q, sum_n;
    logic [TMO_W-1:0]  tmo_q, tmo_n;
    logic [ADDR_W-1:0] waddr_n;
    logic [7:0]        wdata_n;
    logic              wen_n;
    logic              err_inc;
    logic              launch;
    logic              accept;

    logic              buf_we;
    logic [ADDR_W-1:0] buf_raddr;
    logic [7:0]        buf_rdata;
    logic [7:0]        rd_byte;

    assign accept   = rx_valid && rx_ready;
    assign rx_ready = (state != S_COMMIT);
    assign busy     = (state != S_IDLE);

    assign buf_we    = accept && (state == S_DATA);
    assign buf_raddr = (state == S_COMMIT) ? idx_q[ADDR_W-1:0] : '0;
    // Without a checksum the first write launches on the same edge the last byte lands
    assign rd_byte   = (buf_we && (idx_q[ADDR_W-1:0] == buf_raddr)) ? rx_data : buf_rdata;

    psx_loader_buffer u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (idx_q[ADDR_W-1:0]),
        .wr_data (rx_data),
        .rd_addr (buf_raddr),
        .rd_data (buf_rdata)
    );

    always_comb begin
        state_n = state;
        start_n = start_q;
        len_n   = len_q;
        idx_n   = idx_q;
        sum_n   = sum_q;
        tmo_n   = '0;
        waddr_n = write_addr;
        wdata_n = write_data;
        wen_n   = 1'b0;
        err_inc = 1'b0;
        launch  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_header(rx_data)) begin
                    start_n = rx_data[ADDR_W-1:0];
                    sum_n   = rx_data;
                    state_n = S_LENGTH;
                end
            end
            S_LENGTH, S_DATA, S_CHECK: begin
                if (!accept) begin
                    if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
                        state_n = S_IDLE;
                        err_inc = 1'b1;
                    end else begin
                        tmo_n = tmo_q + 1'b1;
                    end
                end else if (state == S_LENGTH) begin
                    if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                        state_n = S_IDLE;
                        err_inc = 1'b1;
                    end else begin
                        len_n   = rx_data[5:0];
                        idx_n   = '0;
                        sum_n   = sum_q + rx_data;
                        state_n = S_DATA;
                    end
                end else if (state == S_DATA) begin
                    sum_n = sum_q + rx_data;
                    idx_n = idx_q + 6'd1;
                    if (idx_q + 6'd1 == len_q) begin
`ifdef PSX_LOADER_CHECKSUM_EN
                        state_n = S_CHECK;
`else
                        launch  = 1'b1;
`endif
                    end
                end else begin
                    if (sum_q + rx_data == 8'h00) begin
                        launch = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                        err_inc = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                if (idx_q < len_q) begin
                    wen_n   = 1'b1;
                    waddr_n = start_q + idx_q[ADDR_W-1:0];
                    wdata_n = rd_byte;
                    idx_n   = idx_q + 6'd1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // First write goes out on the edge that accepts the final byte
        if (launch) begin
            state_n = S_COMMIT;
            wen_n   = 1'b1;
            waddr_n = start_q;
            wdata_n = rd_byte;
            idx_n   = 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            start_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            tmo_q      <= '0;
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            start_q    <= start_n;
            len_q      <= len_n;
            idx_q      <= idx_n;
            sum_q      <= sum_n;
            tmo_q      <= tmo_n;
            write_en   <= wen_n;
            write_addr <= waddr_n;
            write_data <= wdata_n;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_psx_source_loader.sv
// Scoreboard bench for psx_source_loader; follows PSX_LOADER_CHECKSUM_EN like the RTL.
module tb_psx_source_loader;

    typedef logic [7:0] bytes_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [4:0] write_addr;
    logic [7:0] write_data;
    logic       write_en;
    logic       busy;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    logic [12:0] exp_q[$];

    psx_source_loader #(.CLOCK_MHZ(25)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .write_addr (write_addr),
        .write_data (write_data),
        .write_en   (write_en),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data)
    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         write_addr, write_data);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {27'd0, write_addr}, {27'd0, e[12:8]});
                chk("write_data", {24'd0, write_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit done = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        rx_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got rx_ready low expected accept of 0x%0h", b);
        end
    endtask

    task automatic send_pkt(input bytes_t pkt, input logic [7:0] cs);
        foreach (pkt[i]) send(pkt[i]);
`ifdef PSX_LOADER_CHECKSUM_EN
        send(cs);
`endif
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic drain(input string name);
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        do_reset();
        chk("rst_rx_ready", {31'd0, rx_ready}, 1);
        chk("rst_write_en", {31'd0, write_en}, 0);
        chk("rst_write_addr", {27'd0, write_addr}, 0);
        chk("rst_write_data", {24'd0, write_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_err", {24'd0, err_count}, 0);

        // Basic two-byte packet
        expect_wr(5'h03, 8'h11);
        expect_wr(5'h04, 8'h22);
        send_pkt('{8'h83, 8'h02, 8'h11, 8'h22}, 8'h48);
        chk("commit_rx_ready", {31'd0, rx_ready}, 0);
        chk("commit_busy", {31'd0, busy}, 1);
        drain("basic");
        chk("basic_err", {24'd0, err_count}, 0);

        // Address wrap 0x1F -> 0x00
        expect_wr(5'h1F, 8'hAA);
        expect_wr(5'h00, 8'hBB);
        send_pkt('{8'h9F, 8'h02, 8'hAA, 8'hBB}, 8'hFA);
        drain("wrap");
        chk("wrap_err", {24'd0, err_count}, 0);

`ifdef PSX_LOADER_CHECKSUM_EN
        // Bad checksum: no writes, one error
        send_pkt('{8'h83, 8'h02, 8'h11, 8'h22}, 8'h49);
        drain("badcs");
        chk("badcs_err", {24'd0, err_count}, 1);
`endif

        // Stray bytes ignored without error
        do_reset();
        send(8'h05);
        send(8'h20);
        send(8'h41);
        chk("stray_idle", {31'd0, busy}, 0);
        expect_wr(5'h01, 8'h5A);
        send_pkt('{8'h81, 8'h01, 8'h5A}, 8'h24);
        drain("stray");
        chk("stray_err", {24'd0, err_count}, 0);

        // Inter-byte timeout mid-data, then recovery
        do_reset();
        send(8'h80);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        repeat (25010) @(posedge clk);
        #1;
        chk("tmo_idle", {31'd0, busy}, 0);
        chk("tmo_err", {24'd0, err_count}, 1);
        expect_wr(5'h03, 8'h11);
        expect_wr(5'h04, 8'h22);
        send_pkt('{8'h83, 8'h02, 8'h11, 8'h22}, 8'h48);
        drain("tmo_next");
        chk("tmo_next_err", {24'd0, err_count}, 1);

        // Bad lengths, then reset during the second commit cycle
        do_reset();
        send(8'h80);
        send(8'h00);
        send(8'h80);
        send(8'h21);
        drain("badlen");
        chk("badlen_err", {24'd0, err_count}, 2);
        expect_wr(5'h05, 8'h01);
        expect_wr(5'h06, 8'h02);
        send_pkt('{8'h85, 8'h03, 8'h01, 8'h02, 8'h03}, 8'h72);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_write_en", {31'd0, write_en}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        drain("midrst");

        // err_count saturates at 255
        for (int i = 0; i < 260; i++) begin
            send(8'h80);
            send(8'h00);
        end
        chk("sat_err", {24'd0, err_count}, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psx_source_loader.md
PSX_SOURCE_LOADER -- requirements
Module: psx_source_loader

Interface
REQ-001 SHALL have parameter CLOCK_MHZ, default 25, the clk frequency in MHz, used to derive the inter-byte timeout.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rx_data, input, 8 bits: byte from the host stream.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_data is valid.
REQ-006 SHALL have port rx_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-007 SHALL have port write_addr, output, 5 bits: data-source write address toward psx_quad_controller.
REQ-008 SHALL have port write_data, output, 8 bits: write byte.
REQ-009 SHALL have port write_en, output, 1 bit: one-cycle write strobe.
REQ-010 SHALL have port busy, output, 1 bit: high whenever state is not S_IDLE.
REQ-011 SHALL have port err_count, output, 8 bits: count of rejected packets, saturating.

Function
REQ-012 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both high.
REQ-013 SHALL use the packet format: header (bit 7 = 1, bits 6:5 = 0, bits 4:0 = start address), length (1..32), the data bytes, then the checksum byte.
REQ-014 SHALL implement states S_IDLE, S_LENGTH, S_DATA, S_CHECK and S_COMMIT.
REQ-015 SHALL, in S_IDLE, silently discard any byte with bit 7 = 0, or with bits 6:5 != 0, without counting an error; a valid header SHALL latch the address and move to S_LENGTH.
REQ-016 SHALL, in S_LENGTH, reject length 0 or length > 32 by returning to S_IDLE and incrementing err_count; otherwise it SHALL latch the length and move to S_DATA.
REQ-017 SHALL, in S_DATA, store each byte into buffer slot 0..len-1 and move to S_CHECK after the len-th byte.
REQ-018 SHALL, in S_CHECK, go to S_COMMIT if the 8-bit modulo-256 sum of header, length, data and checksum is 0x00; otherwise it SHALL discard the buffer, increment err_count and return to S_IDLE.
REQ-019 SHALL hold rx_ready high in every state except S_COMMIT.
REQ-020 SHALL, in S_COMMIT, assert write_en on len consecutive cycles, the first one in the cycle after the checksum is accepted.
REQ-021 SHALL drive write_addr = (start + i) mod 32 in S_COMMIT, so the address wraps from 0x1F to 0x00.
REQ-022 SHALL register write_addr, write_data and write_en.
REQ-023 SHALL return to S_IDLE after the last write, with rx_ready high in the following cycle.
REQ-024 SHALL clear the timeout counter on every accepted byte.
REQ-025 SHALL, if the timeout counter reaches CLOCK_MHZ*1000 cycles (1 ms) while in S_LENGTH, S_DATA or S_CHECK, abort to S_IDLE and increment err_count.
REQ-026 SHALL never let the timeout fire in S_IDLE or S_COMMIT.
REQ-027 SHALL hold err_count at 255 on further errors, with no wrap.
REQ-028 SHALL apply packet-level errors only before commit, so a packet is written in full or not at all.

Reset
REQ-029 SHALL, on reset (synchronous, active-high), set state to S_IDLE, rx_ready to 1, write_en to 0, write_addr to 0, write_data to 0, busy to 0, err_count to 0 and the timeout counter to 0.
REQ-030 SHALL, if reset is asserted mid-commit, stop write_en on the next clock edge, leaving remaining bytes unwritten, and discard the buffer contents.

Configuration
REQ-031 SHALL, with PSX_LOADER_CHECKSUM_EN defined, implement S_CHECK as specified above.
REQ-032 SHALL, without PSX_LOADER_CHECKSUM_EN, omit S_CHECK and the checksum byte from the packet, entering S_COMMIT in the cycle after the len-th data byte is accepted.

Structure
REQ-033 SHALL take the state encodings, the header mask and reserved-bit constants, and MAX_LEN = 32 from the shared psx_defs package/include.
REQ-034 SHALL implement the 32x8 packet buffer as sub-module psx_loader_buffer: one synchronous write port and one read port.

Verification
REQ-035 SHALL cover, with checksum enabled, the packet 0x83 0x02 0x11 0x22 0x48 -> writes (0x03,0x11) then (0x04,0x22) on consecutive cycles, with err_count = 0.
REQ-036 SHALL cover the packet 0x9F 0x02 0xAA 0xBB with a correct checksum -> writes at addresses 0x1F then 0x00.
REQ-037 SHALL cover 0x83 0x02 0x11 0x22 0x49 -> no write_en pulses and err_count = 1.
REQ-038 SHALL cover the stray bytes 0x05 0x20 0x41 followed by a valid packet -> the stray bytes are ignored without error, the packet commits, and err_count = 0.
REQ-039 SHALL cover header 0x80, length 0x04, then a 25000-cycle gap after two data bytes (CLOCK_MHZ = 25) -> abort, err_count = 1, and the next packet is accepted.
REQ-040 SHALL cover a length byte of 0x00 and one of 0x21 -> each is rejected, err_count = 2, with no writes; and reset asserted on the second commit cycle -> write_en = 0 from the next cycle.
